// File: rtl/move_permit_probe.sv
// Per-frame wall probe around a pacman snapshot: counts wall pixels on the four
// edges just outside the sprite and publishes registered can-go permits once per frame.
module move_permit_probe #(
    parameter int PIXEL_SIZE    = 28,
    parameter int H_ACTIVE      = 640,
    parameter int V_ACTIVE      = 480,
    parameter int HIT_THRESHOLD = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       bright,
    input  logic [9:0] hCount,
    input  logic [9:0] vCount,
    input  logic       wallFill,
    input  logic [9:0] pacX,
    input  logic [9:0] pacY,
    input  logic       permit_ack,
    output logic       cgLeft,
    output logic       cgUp,
    output logic       cgRight,
    output logic       cgDown,
    output logic       permit_valid,
    output logic       overrun,
    output logic       scan_busy,
    output logic [1:0] probe_state
);

    typedef enum logic [1:0] {
        SYNC    = 2'd0,
        ARM     = 2'd1,
        SCAN    = 2'd2,
        PUBLISH = 2'd3
    } state_t;

    localparam logic [10:0] HALF   = 11'(PIXEL_SIZE / 2);
    localparam logic [10:0] H_MAX  = 11'(H_ACTIVE - 1);
    localparam logic [10:0] V_MAX  = 11'(V_ACTIVE - 1);
    localparam logic [9:0]  V_LAST = 10'(V_ACTIVE);
    localparam logic [4:0]  CNT_MAX = 5'd31;

    // Direction index used by every per-edge vector: 0 left, 1 up, 2 right, 3 down.
    state_t     state, state_nxt;
    logic [9:0] sx, sy;
    logic [4:0] cnt [4];
    logic [3:0] cg;

    logic frame_start, frame_end;
    logic snap_en, clear_cnt, count_en, publish;

    assign frame_start = (hCount == 10'd0) && (vCount == 10'd0);
    assign frame_end   = (hCount == 10'd0) && (vCount == V_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= SYNC;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        snap_en   = 1'b0;
        clear_cnt = 1'b0;
        count_en  = 1'b0;
        publish   = 1'b0;
        case (state)
            SYNC: begin
                if (frame_end) begin
                    snap_en   = 1'b1;
                    clear_cnt = 1'b1;
                    state_nxt = ARM;
                end
            end
            ARM: begin
                if (frame_start) begin
                    count_en  = 1'b1;
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                // A repeated frame start here is just another pixel; only the
                // V_ACTIVE line start closes the scan, and that pixel is not counted.
                if (frame_end) state_nxt = PUBLISH;
                else           count_en  = 1'b1;
            end
            PUBLISH: begin
                publish   = 1'b1;
                snap_en   = 1'b1;
                clear_cnt = 1'b1;
                state_nxt = ARM;
            end
            default: state_nxt = SYNC;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sx <= '0;
            sy <= '0;
        end else if (snap_en) begin
            sx <= pacX;
            sy <= pacY;
        end
    end

    // Edge geometry at 11 bits; an underflowed left/up coordinate lands above
    // 1023 and so can never match a 10-bit scan position.
    logic [10:0] sx11, sy11, hc11, vc11;
    logic [10:0] left_h, right_h, up_v, down_v;
    logic        h_in_span, v_in_span;
    logic [3:0]  on_edge, in_bounds;

    assign sx11 = {1'b0, sx};
    assign sy11 = {1'b0, sy};
    assign hc11 = {1'b0, hCount};
    assign vc11 = {1'b0, vCount};

    assign left_h  = sx11 - HALF;
    assign right_h = sx11 + HALF + 11'd1;
    assign up_v    = sy11 - HALF;
    assign down_v  = sy11 + HALF + 11'd1;

    assign h_in_span = (hc11 + HALF > sx11) && (hc11 <= sx11 + HALF);
    assign v_in_span = (vc11 + HALF > sy11) && (vc11 <= sy11 + HALF);

    assign on_edge[0] = (hc11 == left_h)  && v_in_span;
    assign on_edge[1] = (vc11 == up_v)    && h_in_span;
    assign on_edge[2] = (hc11 == right_h) && v_in_span;
    assign on_edge[3] = (vc11 == down_v)  && h_in_span;

    assign in_bounds[0] = (sx11 >= HALF);
    assign in_bounds[1] = (sy11 >= HALF);
    assign in_bounds[2] = (right_h <= H_MAX);
    assign in_bounds[3] = (down_v <= V_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else if (clear_cnt) begin
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else if (count_en && bright && wallFill) begin
            for (int i = 0; i < 4; i++) begin
                if (on_edge[i] && (cnt[i] != CNT_MAX)) cnt[i] <= cnt[i] + 5'd1;
            end
        end
    end

    logic [3:0] cg_nxt;

    always_comb begin
        cg_nxt = '0;
        for (int i = 0; i < 4; i++) begin
            cg_nxt[i] = (int'(cnt[i]) < HIT_THRESHOLD) && in_bounds[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)        cg <= '0;
        else if (publish) cg <= cg_nxt;
    end

    // Handshake: permit_valid rises on publish and holds until a cycle with
    // permit_valid && permit_ack; a publish in that same cycle keeps it high.
    // A publish while still valid and unacknowledged latches overrun until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            permit_valid <= 1'b0;
            overrun      <= 1'b0;
        end else if (publish) begin
            permit_valid <= 1'b1;
            if (permit_valid && !permit_ack) overrun <= 1'b1;
        end else if (permit_valid && permit_ack) begin
            permit_valid <= 1'b0;
        end
    end

    assign cgLeft      = cg[0];
    assign cgUp        = cg[1];
    assign cgRight     = cg[2];
    assign cgDown      = cg[3];
    assign scan_busy   = (state == SCAN);
    assign probe_state = state;

endmodule

// File: tb/tb_move_permit_probe.sv
// Directed bench for move_permit_probe: sparse scan frames with hand-placed wall
// pixels, checking permits, handshake, bounds, snapshot timing and reset.
module tb_move_permit_probe;

    logic       clk = 1'b0;
    logic       reset;
    logic       bright, wallFill, permit_ack;
    logic [9:0] hCount, vCount, pacX, pacY;

    logic       cgLeft, cgUp, cgRight, cgDown, permit_valid, overrun, scan_busy;
    logic [1:0] probe_state;
    logic       cgLeft2, cgUp2, cgRight2, cgDown2, permit_valid2, overrun2, scan_busy2;
    logic [1:0] probe_state2;

    wire [3:0] cg1 = {cgDown, cgRight, cgUp, cgLeft};
    wire [3:0] cg2 = {cgDown2, cgRight2, cgUp2, cgLeft2};

    int total  = 0;
    int passed = 0;
    int wall_h[$];
    int wall_v[$];

    localparam logic [1:0] S_SYNC = 2'd0, S_ARM = 2'd1, S_SCAN = 2'd2, S_PUB = 2'd3;

    // cg vectors read {down, right, up, left}
    localparam logic [3:0] ALL_GO   = 4'b1111;
    localparam logic [3:0] NO_LEFT  = 4'b1110;

    move_permit_probe dut (
        .clk(clk), .reset(reset), .bright(bright), .hCount(hCount), .vCount(vCount),
        .wallFill(wallFill), .pacX(pacX), .pacY(pacY), .permit_ack(permit_ack),
        .cgLeft(cgLeft), .cgUp(cgUp), .cgRight(cgRight), .cgDown(cgDown),
        .permit_valid(permit_valid), .overrun(overrun), .scan_busy(scan_busy),
        .probe_state(probe_state)
    );

    move_permit_probe #(.HIT_THRESHOLD(2)) dut2 (
        .clk(clk), .reset(reset), .bright(bright), .hCount(hCount), .vCount(vCount),
        .wallFill(wallFill), .pacX(pacX), .pacY(pacY), .permit_ack(permit_ack),
        .cgLeft(cgLeft2), .cgUp(cgUp2), .cgRight(cgRight2), .cgDown(cgDown2),
        .permit_valid(permit_valid2), .overrun(overrun2), .scan_busy(scan_busy2),
        .probe_state(probe_state2)
    );

    always #5 clk = ~clk;

    // One scan pixel: driven on the falling edge, results observed just after the rising edge.
    task automatic pix(input int h, input int v, input logic b, input logic w);
        @(negedge clk);
        hCount   = 10'(h);
        vCount   = 10'(v);
        bright   = b;
        wallFill = w;
        @(posedge clk);
        #1;
    endtask

    // Frame from ARM: start pixel, filler, queued wall pixels, frame end, publish cycle.
    task automatic run_frame(input logic ack_start, input logic ack_pub);
        permit_ack = ack_start;
        pix(0, 0, 1'b1, 1'b0);
        permit_ack = 1'b0;
        pix(100, 100, 1'b1, 1'b0);
        pix(286, 300, 1'b0, 1'b1);
        foreach (wall_h[i]) pix(wall_h[i], wall_v[i], 1'b1, 1'b1);
        pix(0, 480, 1'b0, 1'b0);
        permit_ack = ack_pub;
        pix(1, 480, 1'b0, 1'b0);
        permit_ack = 1'b0;
        wall_h.delete();
        wall_v.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; bright = 0; wallFill = 0; permit_ack = 0;
        hCount = 0; vCount = 0; pacX = 10'd300; pacY = 10'd300;
        repeat (3) @(posedge clk);
        #1;
        total++; if (probe_state !== S_SYNC) $display("FAIL reset_state got %0d exp %0d", probe_state, S_SYNC); else passed++;
        total++; if (cg1 !== 4'b0000) $display("FAIL reset_cg got %b exp 0000", cg1); else passed++;
        total++; if (permit_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", permit_valid); else passed++;
        total++; if (overrun !== 1'b0) $display("FAIL reset_overrun got %b exp 0", overrun); else passed++;
        total++; if (scan_busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", scan_busy); else passed++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_open_field();
        pix(0, 0, 1'b1, 1'b0);
        total++; if (probe_state !== S_SYNC) $display("FAIL open_sync_hold got %0d exp %0d", probe_state, S_SYNC); else passed++;
        pix(0, 480, 1'b0, 1'b0);
        total++; if (probe_state !== S_ARM) $display("FAIL open_arm got %0d exp %0d", probe_state, S_ARM); else passed++;
        total++; if (permit_valid !== 1'b0) $display("FAIL open_no_early_pub got %b exp 0", permit_valid); else passed++;
        run_frame(1'b0, 1'b0);
        total++; if (cg1 !== ALL_GO) $display("FAIL open_cg got %b exp %b", cg1, ALL_GO); else passed++;
        total++; if (cg2 !== ALL_GO) $display("FAIL open_cg_t2 got %b exp %b", cg2, ALL_GO); else passed++;
        total++; if (permit_valid !== 1'b1) $display("FAIL open_valid got %b exp 1", permit_valid); else passed++;
        total++; if (permit_valid2 !== 1'b1) $display("FAIL open_valid_t2 got %b exp 1", permit_valid2); else passed++;
        total++; if (probe_state !== S_ARM) $display("FAIL open_back_to_arm got %0d exp %0d", probe_state, S_ARM); else passed++;
    endtask

    task automatic test_single_wall();
        permit_ack = 1'b1;
        pix(0, 0, 1'b1, 1'b0);
        permit_ack = 1'b0;
        total++; if (permit_valid !== 1'b0) $display("FAIL ack_clears got %b exp 0", permit_valid); else passed++;
        total++; if (scan_busy !== 1'b1) $display("FAIL scan_busy got %b exp 1", scan_busy); else passed++;
        pix(286, 300, 1'b1, 1'b1);
        pix(0, 0, 1'b1, 1'b0);
        total++; if (probe_state !== S_SCAN) $display("FAIL restart_ignored got %0d exp %0d", probe_state, S_SCAN); else passed++;
        pix(0, 480, 1'b0, 1'b0);
        total++; if (probe_state !== S_PUB) $display("FAIL publish_state got %0d exp %0d", probe_state, S_PUB); else passed++;
        total++; if (cg1 !== ALL_GO) $display("FAIL cg_hold_before_pub got %b exp %b", cg1, ALL_GO); else passed++;
        pix(1, 480, 1'b0, 1'b0);
        total++; if (cg1 !== NO_LEFT) $display("FAIL wall_cg got %b exp %b", cg1, NO_LEFT); else passed++;
        total++; if (cg2 !== ALL_GO) $display("FAIL wall_cg_t2 got %b exp %b", cg2, ALL_GO); else passed++;
        total++; if (overrun !== 1'b0) $display("FAIL wall_overrun got %b exp 0", overrun); else passed++;
    endtask

    task automatic test_edges();
        // Pixels one step off each edge or span, with SX=SY=300 (edges h=286/315, v=286/315).
        wall_h = '{285, 286, 287, 286, 314}; wall_v = '{300, 286, 300, 315, 316};
        run_frame(1'b1, 1'b0);
        total++; if (cg1 !== ALL_GO) $display("FAIL edge_miss got %b exp %b", cg1, ALL_GO); else passed++;
        wall_h = '{315, 314, 287}; wall_v = '{314, 315, 286};
        run_frame(1'b1, 1'b0);
        total++; if (cg1 !== 4'b0001) $display("FAIL edge_hits got %b exp 0001", cg1); else passed++;
        total++; if (cg2 !== ALL_GO) $display("FAIL edge_hits_t2 got %b exp %b", cg2, ALL_GO); else passed++;
        wall_h = '{286, 286}; wall_v = '{287, 314};
        run_frame(1'b1, 1'b0);
        total++; if (cg2 !== NO_LEFT) $display("FAIL threshold_two got %b exp %b", cg2, NO_LEFT); else passed++;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 33; i++) begin
            wall_h.push_back(286);
            wall_v.push_back(300);
        end
        run_frame(1'b1, 1'b0);
        total++; if (cg1 !== NO_LEFT) $display("FAIL sat_cg got %b exp %b", cg1, NO_LEFT); else passed++;
        total++; if (cg2 !== NO_LEFT) $display("FAIL sat_cg_t2 got %b exp %b", cg2, NO_LEFT); else passed++;
    endtask

    task automatic test_bounds();
        pacX = 10'd10; pacY = 10'd470;
        run_frame(1'b1, 1'b0);
        total++; if (cg1 !== ALL_GO) $display("FAIL bounds_latency got %b exp %b", cg1, ALL_GO); else passed++;
        pacX = 10'd14; pacY = 10'd464;
        run_frame(1'b1, 1'b0);
        total++; if (cg1 !== 4'b0110) $display("FAIL bounds_low got %b exp 0110", cg1); else passed++;
        pacX = 10'd625; pacY = 10'd13;
        run_frame(1'b1, 1'b0);
        total++; if (cg1 !== ALL_GO) $display("FAIL bounds_exact got %b exp %b", cg1, ALL_GO); else passed++;
        pacX = 10'd300; pacY = 10'd300;
        run_frame(1'b1, 1'b0);
        total++; if (cg1 !== 4'b1001) $display("FAIL bounds_high got %b exp 1001", cg1); else passed++;
    endtask

    task automatic test_snapshot();
        permit_ack = 1'b1;
        pix(0, 0, 1'b1, 1'b0);
        permit_ack = 1'b0;
        pix(150, 150, 1'b1, 1'b0);
        pacX = 10'd100;
        pix(50, 200, 1'b1, 1'b0);
        pix(286, 300, 1'b1, 1'b1);
        pix(0, 480, 1'b0, 1'b0);
        pix(1, 480, 1'b0, 1'b0);
        total++; if (cg1 !== NO_LEFT) $display("FAIL snap_same_frame got %b exp %b", cg1, NO_LEFT); else passed++;
        wall_h = '{86}; wall_v = '{300};
        run_frame(1'b1, 1'b0);
        total++; if (cg1 !== NO_LEFT) $display("FAIL snap_new_left got %b exp %b", cg1, NO_LEFT); else passed++;
        wall_h = '{286}; wall_v = '{300};
        run_frame(1'b1, 1'b0);
        total++; if (cg1 !== ALL_GO) $display("FAIL snap_old_left got %b exp %b", cg1, ALL_GO); else passed++;
    endtask

    task automatic test_handshake();
        run_frame(1'b0, 1'b1);
        total++; if (permit_valid !== 1'b1) $display("FAIL pub_wins_valid got %b exp 1", permit_valid); else passed++;
        total++; if (overrun !== 1'b0) $display("FAIL pub_wins_overrun got %b exp 0", overrun); else passed++;
        pix(5, 479, 1'b0, 1'b0);
        total++; if (permit_valid !== 1'b1) $display("FAIL valid_holds got %b exp 1", permit_valid); else passed++;
        permit_ack = 1'b1;
        pix(5, 479, 1'b0, 1'b0);
        total++; if (permit_valid !== 1'b0) $display("FAIL ack_clear got %b exp 0", permit_valid); else passed++;
        pix(5, 479, 1'b0, 1'b0);
        permit_ack = 1'b0;
        total++; if (overrun !== 1'b0) $display("FAIL idle_ack_overrun got %b exp 0", overrun); else passed++;
    endtask

    task automatic test_overrun();
        run_frame(1'b0, 1'b0);
        total++; if (overrun !== 1'b0) $display("FAIL overrun_first got %b exp 0", overrun); else passed++;
        run_frame(1'b0, 1'b0);
        total++; if (overrun !== 1'b1) $display("FAIL overrun_second got %b exp 1", overrun); else passed++;
        total++; if (overrun2 !== 1'b1) $display("FAIL overrun_second_t2 got %b exp 1", overrun2); else passed++;
        run_frame(1'b1, 1'b0);
        total++; if (overrun !== 1'b1) $display("FAIL overrun_sticky got %b exp 1", overrun); else passed++;
    endtask

    task automatic test_reset_mid_scan();
        pix(0, 0, 1'b1, 1'b0);
        pix(10, 240, 1'b1, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        total++; if (cg1 !== 4'b0000) $display("FAIL mid_reset_cg got %b exp 0000", cg1); else passed++;
        total++; if (permit_valid !== 1'b0) $display("FAIL mid_reset_valid got %b exp 0", permit_valid); else passed++;
        total++; if (overrun !== 1'b0) $display("FAIL mid_reset_overrun got %b exp 0", overrun); else passed++;
        total++; if (scan_busy !== 1'b0) $display("FAIL mid_reset_busy got %b exp 0", scan_busy); else passed++;
        total++; if (probe_state2 !== S_SYNC) $display("FAIL mid_reset_state got %0d exp %0d", probe_state2, S_SYNC); else passed++;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        pacX = 10'd200; pacY = 10'd200;
        pix(0, 480, 1'b0, 1'b0);
        pix(5, 479, 1'b0, 1'b0);
        total++; if (probe_state !== S_ARM) $display("FAIL post_reset_arm got %0d exp %0d", probe_state, S_ARM); else passed++;
        total++; if (permit_valid !== 1'b0) $display("FAIL post_reset_no_pub got %b exp 0", permit_valid); else passed++;
        run_frame(1'b0, 1'b0);
        total++; if (cg1 !== ALL_GO) $display("FAIL post_reset_cg got %b exp %b", cg1, ALL_GO); else passed++;
        total++; if (permit_valid !== 1'b1) $display("FAIL post_reset_valid got %b exp 1", permit_valid); else passed++;
    endtask

    initial begin
        test_reset();
        test_open_field();
        test_single_wall();
        test_edges();
        test_saturation();
        test_bounds();
        test_snapshot();
        test_handshake();
        test_overrun();
        test_reset_mid_scan();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
